regfile_mp: RTL and testbench

Parametrised multi-port register file for the 8-bit multicycle CPU. It generalises the single-write, dual-read 16×8 register file to configurable width, depth, read-port count and write-port count. It adds synchronous clearing, a hardwired-zero register option, deterministic write-conflict priority and optional write-to-read bypass. It sits between the decode stage (register addresses) and the datapath (ALU operands, writeback).

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_mp_if.sv | 21 ++
 rtl/regfile_bypass.sv | 41 ++++
 rtl/regfile_mp.sv | 70 +++++++
 tb/tb_regfile_mp.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the address/data types used by decode and datapath.
package regfile_pkg;
  localparam int REGFILE_W     = 8;
  localparam int REGFILE_DEPTH = 16;
  localparam int REGFILE_AW    = $clog2(REGFILE_DEPTH);

  typedef logic [REGFILE_AW-1:0] addr_t;
  typedef logic [REGFILE_W-1:0]  data_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: clear strobe, write ports and read ports.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int W     = REGFILE_W,
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int NR    = 2,
  parameter int NW    = 1
);
  localparam int AW = $clog2(DEPTH);

  logic                   clr;
  logic [NW-1:0]          we;
  logic [NW-1:0][AW-1:0]  wa;
  logic [NW-1:0][W-1:0]   wd;
  logic [NR-1:0][AW-1:0]  ra;
  logic [NR-1:0][W-1:0]   rd;

  modport master (output clr, we, wa, wd, ra, input rd);
  modport slave  (input clr, we, wa, wd, ra, output rd);
endinterface

// File: rtl/regfile_bypass.sv
// Per-read-port output stage: optional write-to-read forwarding (REGFILE_BYPASS_EN)
// and the hardwired-zero mask. Without the macro it passes the stored word through.
module regfile_bypass #(
  parameter int W        = 8,
  parameter int AW       = 4,
`ifdef REGFILE_BYPASS_EN
  parameter int NW       = 1,
`endif
  parameter bit ZERO_REG = 1'b0
) (
  input  logic [AW-1:0]         ra_i,
  input  logic [W-1:0]          stored_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                  en_i,
  input  logic [NW-1:0]         we_i,
  input  logic [NW-1:0][AW-1:0] wa_i,
  input  logic [NW-1:0][W-1:0]  wd_i,
`endif
  output logic [W-1:0]          rd_o
);

  logic [W-1:0] word_s;

`ifdef REGFILE_BYPASS_EN
  // Ascending scan: a later (higher-index) matching port overrides earlier ones.
  always_comb begin
    word_s = stored_i;
    for (int i = 0; i < NW; i++) begin
      word_s = (en_i && we_i[i] && (wa_i[i] == ra_i)) ? wd_i[i] : word_s;
    end
  end
`else
  assign word_s = stored_i;
`endif

  // Register 0 reads as zero regardless of storage or forwarding.
  always_comb begin
    rd_o = (ZERO_REG && (ra_i == '0)) ? '0 : word_s;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file (NR reads, NW writes, highest write port wins).
// Optional same-cycle write-to-read forwarding is enabled with REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int W        = REGFILE_W,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter bit ZERO_REG = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] regs_q;
  logic [DEPTH-1:0][W-1:0] regs_d;
  logic [NR-1:0][W-1:0]    stored_s;
  logic [NR-1:0][W-1:0]    rd_s;

  // Clear beats writes; ports applied in ascending order so port NW-1 wins a conflict.
  always_comb begin
    regs_d = regs_q;
    if (bus.clr) begin
      regs_d = '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        regs_d[bus.wa[i]] = (bus.we[i] && !(ZERO_REG && (bus.wa[i] == '0)))
                            ? bus.wd[i] : regs_d[bus.wa[i]];
      end
    end
  end

  // Storage flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    assign stored_s[j] = regs_q[bus.ra[j]];

    regfile_bypass #(
      .W        (W),
      .AW       (AW),
`ifdef REGFILE_BYPASS_EN
      .NW       (NW),
`endif
      .ZERO_REG (ZERO_REG)
    ) u_bypass (
      .ra_i     (bus.ra[j]),
      .stored_i (stored_s[j]),
`ifdef REGFILE_BYPASS_EN
      .en_i     (rst_n && !bus.clr),
      .we_i     (bus.we),
      .wa_i     (bus.wa),
      .wd_i     (bus.wd),
`endif
      .rd_o     (rd_s[j])
    );
  end

  assign bus.rd = rd_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: two register files (ZERO_REG=0 and 1, NW=2, NR=2) driven in
// parallel and compared against an array-based reference model.
module tb_regfile_mp;
  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  clr_s;
  logic [NW-1:0]         we_s;
  logic [NW-1:0][AW-1:0] wa_s;
  logic [NW-1:0][W-1:0]  wd_s;
  logic [NR-1:0][AW-1:0] ra_s;

  regfile_mp_if #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus_a ();
  regfile_mp_if #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus_z ();

  assign bus_a.clr = clr_s;  assign bus_z.clr = clr_s;
  assign bus_a.we  = we_s;   assign bus_z.we  = we_s;
  assign bus_a.wa  = wa_s;   assign bus_z.wa  = wa_s;
  assign bus_a.wd  = wd_s;   assign bus_z.wd  = wd_s;
  assign bus_a.ra  = ra_s;   assign bus_z.ra  = ra_s;

  regfile_mp #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  regfile_mp #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(bus_z));

  logic [W-1:0] mem_a [DEPTH];
  logic [W-1:0] mem_z [DEPTH];
  int checks = 0;
  int errors = 0;

  // Expected read value for port j from the model and the current inputs.
  function automatic logic [W-1:0] exp_rd(input bit zero, input int j);
    logic [AW-1:0] a;
    a = ra_s[j];
    if (zero && a == 4'd0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
    if (rst_n && !clr_s)
      for (int i = NW - 1; i >= 0; i--)
        if (we_s[i] && wa_s[i] == a) return wd_s[i];
`endif
    return zero ? mem_z[a] : mem_a[a];
  endfunction

  // Advance one rising edge, updating the model by the clear/reset/write rules.
  task automatic clock_edge();
    logic [W-1:0] na [DEPTH];
    logic [W-1:0] nz [DEPTH];
    bit taken [DEPTH];
    na = mem_a;
    nz = mem_z;
    taken = '{default: 1'b0};
    if (!rst_n || clr_s) begin
      for (int k = 0; k < DEPTH; k++) begin na[k] = 8'h00; nz[k] = 8'h00; end
    end else begin
      for (int i = NW - 1; i >= 0; i--) begin
        if (we_s[i] && !taken[wa_s[i]]) begin
          taken[wa_s[i]] = 1'b1;
          na[wa_s[i]] = wd_s[i];
          if (wa_s[i] != 4'd0) nz[wa_s[i]] = wd_s[i];
        end
      end
    end
    @(posedge clk);
    mem_a = na;
    mem_z = nz;
    #1;
  endtask

  task automatic drive(input logic [NW-1:0] we, input logic [AW-1:0] wa0, input logic [W-1:0] wd0,
                       input logic [AW-1:0] wa1, input logic [W-1:0] wd1,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input logic clr);
    we_s = we; wa_s[0] = wa0; wd_s[0] = wd0; wa_s[1] = wa1; wd_s[1] = wd1;
    ra_s[0] = ra0; ra_s[1] = ra1; clr_s = clr;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd3, 4'd0, 1'b0);
    clock_edge();
    rst_n = 1'b1;
    drive(2'b01, 4'd3, 8'hA5, 4'd0, 8'h00, 4'd3, 4'd0, 1'b0);
    clock_edge();
    drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd3, 4'd0, 1'b0);
    checks++;
    if (bus_a.rd[0] !== 8'hA5) begin
      errors++; $display("FAIL reset_preload got=%h exp=a5", bus_a.rd[0]);
    end
    rst_n = 1'b0;
    clock_edge();
    for (int a = 0; a < DEPTH; a++) begin
      drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, AW'(a), AW'(DEPTH - 1 - a), 1'b0);
      for (int j = 0; j < NR; j++) begin
        checks++;
        if (bus_a.rd[j] !== 8'h00) begin
          errors++; $display("FAIL reset_a ra=%0d got=%h exp=00", ra_s[j], bus_a.rd[j]);
        end
        checks++;
        if (bus_z.rd[j] !== 8'h00) begin
          errors++; $display("FAIL reset_z ra=%0d got=%h exp=00", ra_s[j], bus_z.rd[j]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(2'b01, 4'd5, 8'h3C, 4'd0, 8'h00, 4'd5, 4'd5, 1'b0);
    for (int j = 0; j < NR; j++) begin
      checks++;
      if (bus_a.rd[j] !== exp_rd(1'b0, j)) begin
        errors++; $display("FAIL basic_pre rd%0d got=%h exp=%h", j, bus_a.rd[j], exp_rd(1'b0, j));
      end
    end
    clock_edge();
    drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd5, 4'd4, 1'b0);
    checks++;
    if (bus_a.rd[0] !== 8'h3C) begin
      errors++; $display("FAIL basic_reg5 got=%h exp=3c", bus_a.rd[0]);
    end
    checks++;
    if (bus_a.rd[1] !== 8'h00) begin
      errors++; $display("FAIL basic_reg4 got=%h exp=00", bus_a.rd[1]);
    end
    checks++;
    if (bus_z.rd[0] !== 8'h3C) begin
      errors++; $display("FAIL basic_z_reg5 got=%h exp=3c", bus_z.rd[0]);
    end
  endtask

  task automatic test_conflict();
    drive(2'b11, 4'd7, 8'h11, 4'd7, 8'h22, 4'd7, 4'd7, 1'b0);
    for (int j = 0; j < NR; j++) begin
      checks++;
      if (bus_a.rd[j] !== exp_rd(1'b0, j)) begin
        errors++; $display("FAIL conflict_pre rd%0d got=%h exp=%h", j, bus_a.rd[j], exp_rd(1'b0, j));
      end
    end
    clock_edge();
    drive(2'b11, 4'd2, 8'h44, 4'd9, 8'h55, 4'd7, 4'd2, 1'b0);
    checks++;
    if (bus_a.rd[0] !== 8'h22) begin
      errors++; $display("FAIL conflict_winner got=%h exp=22", bus_a.rd[0]);
    end
    clock_edge();
    drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd2, 4'd9, 1'b0);
    checks++;
    if (bus_a.rd[0] !== 8'h44) begin
      errors++; $display("FAIL conflict_reg2 got=%h exp=44", bus_a.rd[0]);
    end
    checks++;
    if (bus_a.rd[1] !== 8'h55) begin
      errors++; $display("FAIL conflict_reg9 got=%h exp=55", bus_a.rd[1]);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] pre;
`ifdef REGFILE_BYPASS_EN
    pre = 8'h99;
`else
    pre = 8'h00;
`endif
    drive(2'b01, 4'd6, 8'h99, 4'd0, 8'h00, 4'd6, 4'd5, 1'b0);
    checks++;
    if (bus_a.rd[0] !== pre) begin
      errors++; $display("FAIL bypass_pre got=%h exp=%h", bus_a.rd[0], pre);
    end
    clock_edge();
    drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd6, 4'd5, 1'b0);
    checks++;
    if (bus_a.rd[0] !== 8'h99) begin
      errors++; $display("FAIL bypass_post got=%h exp=99", bus_a.rd[0]);
    end
  endtask

  task automatic test_zero();
    drive(2'b11, 4'd0, 8'hFF, 4'd0, 8'hFF, 4'd0, 4'd0, 1'b0);
    checks++;
    if (bus_z.rd[0] !== 8'h00) begin
      errors++; $display("FAIL zero_pre got=%h exp=00", bus_z.rd[0]);
    end
    checks++;
    if (bus_a.rd[1] !== exp_rd(1'b0, 1)) begin
      errors++; $display("FAIL zero_a_pre got=%h exp=%h", bus_a.rd[1], exp_rd(1'b0, 1));
    end
    clock_edge();
    drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
    checks++;
    if (bus_z.rd[0] !== 8'h00) begin
      errors++; $display("FAIL zero_post got=%h exp=00", bus_z.rd[0]);
    end
    checks++;
    if (bus_a.rd[0] !== 8'hFF) begin
      errors++; $display("FAIL zero_a_post got=%h exp=ff", bus_a.rd[0]);
    end
  endtask

  task automatic test_clr();
    for (int pass = 0; pass < 2; pass++) begin
      drive(2'b01, 4'd1, 8'h12, 4'd0, 8'h00, 4'd1, 4'd2, 1'b0);
      clock_edge();
      if (pass == 1) rst_n = 1'b0;
      drive(2'b01, 4'd2, 8'h34, 4'd0, 8'h00, 4'd2, 4'd1, 1'b1);
      for (int j = 0; j < NR; j++) begin
        checks++;
        if (bus_a.rd[j] !== exp_rd(1'b0, j)) begin
          errors++; $display("FAIL clr_pre%0d rd%0d got=%h exp=%h", pass, j, bus_a.rd[j], exp_rd(1'b0, j));
        end
      end
      clock_edge();
      rst_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
        drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, AW'(a), AW'(DEPTH - 1 - a), 1'b0);
        for (int j = 0; j < NR; j++) begin
          checks++;
          if (bus_a.rd[j] !== 8'h00 || bus_z.rd[j] !== 8'h00) begin
            errors++; $display("FAIL clr_post%0d ra=%0d got=%h/%h exp=00", pass, ra_s[j], bus_a.rd[j], bus_z.rd[j]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(40) != 0);
      drive(NW'($urandom_range(3)), AW'($urandom_range(15)), W'($urandom),
            AW'($urandom_range(15)), W'($urandom),
            AW'($urandom_range(15)), AW'($urandom_range(15)), ($urandom_range(20) == 0));
      for (int j = 0; j < NR; j++) begin
        checks++;
        if (bus_a.rd[j] !== exp_rd(1'b0, j)) begin
          errors++; $display("FAIL rand_a n=%0d rd%0d got=%h exp=%h", n, j, bus_a.rd[j], exp_rd(1'b0, j));
        end
        checks++;
        if (bus_z.rd[j] !== exp_rd(1'b1, j)) begin
          errors++; $display("FAIL rand_z n=%0d rd%0d got=%h exp=%h", n, j, bus_z.rd[j], exp_rd(1'b1, j));
        end
      end
      clock_edge();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_s = 1'b0; we_s = '0; wa_s = '0; wd_s = '0; ra_s = '0;
    for (int k = 0; k < DEPTH; k++) begin mem_a[k] = 8'h00; mem_z[k] = 8'h00; end
    test_reset();
    test_basic();
    test_conflict();
    test_bypass();
    test_zero();
    test_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
